// File: rtl/lsu_store_buffer.sv
// Load/store unit with an in-order store buffer in front of a word-addressed data memory.
// Stores drain whenever the memory port is not used by a load; loads forward from the youngest matching entry.
module lsu_store_buffer #(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [TAG_W-1:0]          req_rd,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [TAG_W-1:0]          resp_rd,
  output logic                      sb_empty,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      mem_write_enable,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  sb_entry_t          entries [SB_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               load_acc;
  logic               store_acc;
  logic               drain;
  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;
  logic [PTR_W-1:0]   idx;

  assign full      = (count == CNT_W'(SB_DEPTH));
  assign req_ready = !full;
  assign load_acc  = req_valid && req_ready && !req_is_store;
  assign store_acc = req_valid && req_ready && req_is_store;
  assign drain     = !load_acc && (count != '0);
  assign sb_empty  = (count == '0);
  assign sb_count  = count;

  // Scan oldest to youngest so the last hit is the entry closest to tail.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  // Memory port: an accepted load owns it, otherwise the head store drains.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_addr         = req_addr;
    mem_wdata        = entries[head].data;
    if (drain) begin
      mem_write_enable = 1'b1;
      mem_addr         = entries[head].addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
    end else begin
      if (store_acc) tail <= tail + PTR_W'(1);
      if (drain)     head <= head + PTR_W'(1);
      case ({store_acc, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      resp_valid <= load_acc;
      if (load_acc) begin
        resp_rdata <= fwd_hit ? fwd_data : mem_rdata;
        resp_rd    <= req_rd;
      end
    end
  end

  // Entry payload needs no reset: occupancy is tracked by head/count only.
  always_ff @(posedge clk) begin
    if (store_acc) entries[tail] <= '{addr: req_addr, data: req_wdata};
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed vector table, async-reset sequence,
// and randomized traffic checked against a queue-based store-buffer model.
module tb_lsu_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  lsu_store_buffer #(.SB_DEPTH(4), .ADDR_W(32), .DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .sb_empty(sb_empty), .sb_count(sb_count),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-word data memory; addresses outside it read 0 and ignore writes.
  logic [31:0] mem [64];
  always_comb mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'd0;
  always @(posedge clk) if (mem_write_enable && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v, st;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        e_we;
    logic [31:0] e_maddr, e_wdata;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic [4:0]  e_rd;
    logic [2:0]  e_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, input logic st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic e_we, input logic [31:0] e_maddr, input logic [31:0] e_wdata,
                              input logic e_rv, input logic [31:0] e_rdata, input logic [4:0] e_rd,
                              input logic [2:0] e_cnt);
    vec_t t;
    t.v = v; t.st = st; t.addr = addr; t.wdata = wdata; t.rd = rd;
    t.e_we = e_we; t.e_maddr = e_maddr; t.e_wdata = e_wdata;
    t.e_rv = e_rv; t.e_rdata = e_rdata; t.e_rd = e_rd; t.e_cnt = e_cnt;
    tbl.push_back(t);
  endfunction

  typedef struct {logic [31:0] addr; logic [31:0] data;} ent_t;
  ent_t        mq[$];
  logic [31:0] mem_m [64];

  initial begin
    logic        v, st, ld, sto, e_ready, e_we, m_rv;
    logic [31:0] a, d, e_maddr, e_wd, ld_data, m_rdata;
    logic [4:0]  r, m_rd;

    // v st addr wdata rd | we maddr wdata | rv rdata rd | count
    add(0,0,0,0,0,              0,0,0,                  0,0,0,0);
    add(1,0,0,0,3,              0,0,0,                  0,0,0,0);
    add(0,0,0,0,0,              0,0,0,                  1,9,3,0);
    add(1,1,3,32'hFFFFFFC8,0,   0,3,0,                  0,0,0,0);
    add(0,0,0,0,0,              1,3,32'hFFFFFFC8,       0,0,0,1);
    add(0,0,0,0,0,              0,0,0,                  0,0,0,0);
    add(1,0,3,0,1,              0,3,0,                  0,0,0,0);
    add(0,0,0,0,0,              0,0,0,                  1,32'hFFFFFFC8,1,0);
    add(1,1,5,17,0,             0,5,0,                  0,0,0,0);
    add(1,0,5,0,2,              0,5,0,                  0,0,0,1);
    add(0,0,0,0,0,              1,5,17,                 1,17,2,1);
    add(1,0,5,0,4,              0,5,0,                  0,0,0,0);
    add(0,0,0,0,0,              0,0,0,                  1,17,4,0);
    add(1,1,7,2938,0,           0,7,0,                  0,0,0,0);
    add(1,0,9,0,5,              0,9,0,                  0,0,0,1);
    add(1,1,7,100,0,            1,7,2938,               1,11,5,1);
    add(1,0,7,0,6,              0,7,0,                  0,0,0,1);
    add(0,0,0,0,0,              1,7,100,                1,100,6,1);
    add(0,0,0,0,0,              0,0,0,                  0,0,0,0);
    add(1,0,7,0,7,              0,7,0,                  0,0,0,0);
    add(0,0,0,0,0,              0,0,0,                  1,100,7,0);
    add(1,1,20,32'hA0,0,        0,20,0,                 0,0,0,0);
    add(1,0,21,0,8,             0,21,0,                 0,0,0,1);
    add(1,1,22,32'hA2,0,        1,20,32'hA0,            1,32'h115,8,1);
    add(1,0,23,0,9,             0,23,0,                 0,0,0,1);
    add(1,1,24,32'hA4,0,        1,22,32'hA2,            1,32'h117,9,1);
    add(1,0,25,0,10,            0,25,0,                 0,0,0,1);
    add(1,1,26,32'hA6,0,        1,24,32'hA4,            1,32'h119,10,1);
    add(0,0,0,0,0,              1,26,32'hA6,            0,0,0,1);
    add(0,0,0,0,0,              0,0,0,                  0,0,0,0);
    add(1,0,20,0,11,            0,20,0,                 0,0,0,0);
    add(1,0,26,0,12,            0,26,0,                 1,32'hA0,11,0);
    add(0,0,0,0,0,              0,0,0,                  1,32'hA6,12,0);
    add(1,1,32'h10005,32'h55,0, 0,32'h10005,0,          0,0,0,0);
    add(1,0,5,0,13,             0,5,0,                  0,0,0,1);
    add(0,0,0,0,0,              1,32'h10005,32'h55,     1,17,13,1);
    add(0,0,0,0,0,              0,0,0,                  0,0,0,0);

    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
    mem[0] = 9; mem[5] = 44; mem[7] = 0; mem[9] = 11;

    rst_n = 1'b0; req_valid = 0; req_is_store = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    #1;
    chk("rst count", 32'(sb_count), 0);
    chk("rst empty", 32'(sb_empty), 1);
    chk("rst resp_valid", 32'(resp_valid), 0);
    chk("rst we", 32'(mem_write_enable), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_is_store = tbl[i].st; req_addr = tbl[i].addr;
      req_wdata = tbl[i].wdata; req_rd = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d ready", i), 32'(req_ready), 1);
      chk($sformatf("v%0d we", i), 32'(mem_write_enable), 32'(tbl[i].e_we));
      chk($sformatf("v%0d maddr", i), mem_addr, tbl[i].e_maddr);
      if (tbl[i].e_we) chk($sformatf("v%0d wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d rdata", i), resp_rdata, tbl[i].e_rdata);
        chk($sformatf("v%0d resp_rd", i), 32'(resp_rd), 32'(tbl[i].e_rd));
      end
      chk($sformatf("v%0d count", i), 32'(sb_count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d empty", i), 32'(sb_empty), 32'(tbl[i].e_cnt == 3'd0));
      @(posedge clk); #1;
    end
    chk("mem3 drained", mem[3], 32'hFFFFFFC8);
    chk("mem7 final", mem[7], 100);

    // Async reset with a store still pending: it must never reach memory.
    req_valid = 1; req_is_store = 1; req_addr = 40; req_wdata = 32'hDEAD; req_rd = 0;
    @(negedge clk);
    chk("rs store we", 32'(mem_write_enable), 0);
    @(posedge clk); #1;
    req_is_store = 0; req_addr = 41; req_rd = 1;
    @(negedge clk);
    chk("rs load count", 32'(sb_count), 1);
    @(posedge clk); #1;
    req_valid = 0; req_addr = 0;
    #1;
    chk("rs pre resp_valid", 32'(resp_valid), 1);
    chk("rs pre we", 32'(mem_write_enable), 1);
    rst_n = 1'b0;
    #1;
    chk("rs count", 32'(sb_count), 0);
    chk("rs we", 32'(mem_write_enable), 0);
    chk("rs resp_valid", 32'(resp_valid), 0);
    chk("rs empty", 32'(sb_empty), 1);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rs after we", 32'(mem_write_enable), 0);
      chk("rs after count", 32'(sb_count), 0);
    end
    chk("rs mem40 untouched", mem[40], 32'h128);
    @(posedge clk); #1;

    // Randomized traffic against a queue model.
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      mem_m[i] = mem[i];
    end
    m_rv = 0; m_rdata = 0; m_rd = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 9) < 7); st = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 15); d = $urandom; r = 5'($urandom);
      req_valid = v; req_is_store = st; req_addr = a; req_wdata = d; req_rd = r;
      @(negedge clk);
      e_ready = (mq.size() < 4);
      ld = v && e_ready && !st;
      sto = v && e_ready && st;
      e_we = 0; e_maddr = a; e_wd = 0; ld_data = 0;
      if (ld) begin
        ld_data = mem_m[a[5:0]];
        foreach (mq[k]) if (mq[k].addr == a) ld_data = mq[k].data;
      end else if (mq.size() > 0) begin
        e_we = 1; e_maddr = mq[0].addr; e_wd = mq[0].data;
      end
      chk("rnd ready", 32'(req_ready), 32'(e_ready));
      chk("rnd we", 32'(mem_write_enable), 32'(e_we));
      chk("rnd maddr", mem_addr, e_maddr);
      if (e_we) chk("rnd wdata", mem_wdata, e_wd);
      chk("rnd resp_valid", 32'(resp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rnd rdata", resp_rdata, m_rdata);
        chk("rnd resp_rd", 32'(resp_rd), 32'(m_rd));
      end
      chk("rnd count", 32'(sb_count), 32'(mq.size()));
      @(posedge clk);
      if (e_we) begin
        mem_m[e_maddr[5:0]] = e_wd;
        void'(mq.pop_front());
      end
      if (sto) mq.push_back('{addr: a, data: d});
      m_rv = ld;
      if (ld) begin m_rdata = ld_data; m_rd = r; end
      #1;
    end
    req_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("rnd mem%0d", i), mem[i], mem_m[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
